// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command parser and the SPI slave it sits behind.
package spi_pkg;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_TIMEOUT = 5000;
    localparam int CMD_RW_BIT  = SPI_DATA_W - 1;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } state_e;

endpackage

// File: rtl/spi_frame_timer.sv
// Inter-byte frame timer: counts idle cycles up to LIMIT, clears and holds on command.
module spi_frame_timer #(
    parameter int TIMEOUT = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_at_limit
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturating idle counter; the owning FSM leaves its wait state at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_hold) begin
            r_cnt <= r_cnt;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/spi_cmd_regbank.sv
// Two-byte SPI command parser (command, data) driving a local configuration register bank.
module spi_cmd_regbank
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = SPI_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             rx_data,
    input  logic                          byte_begin,
    input  logic                          byte_end,
    output logic [DATA_W-1:0]             tx_data,
    output logic [(2**ADDR_W)*DATA_W-1:0] regs_flat,
    output logic                          wr_pulse,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic                          rd_pulse,
    output logic                          timeout_err,
    output logic                          busy
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int RW_BIT   = DATA_W - 1;

    state_e              r_state;
    state_e              w_next_state;
    logic                r_in_byte;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_tx;
    logic                r_wr_pulse;
    logic                r_rd_pulse;
    logic                r_timeout;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_busy;

    logic                w_latch_cmd;
    logic                w_wr_en;
    logic                w_rd_accept;
    logic                w_tx_load;
    logic                w_tx_clear;
    logic                w_timeout;
    logic                w_at_limit;
    logic                w_timer_clear;
    logic [ADDR_W-1:0]   w_cmd_addr;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_regs [NUM_REGS];

    assign w_cmd_addr    = rx_data[ADDR_W-1:0];
    assign w_timer_clear = (r_state == ST_IDLE) || byte_begin;

    spi_frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_timer_clear),
        .i_hold     (r_in_byte),
        .o_at_limit (w_at_limit)
    );

    // Chip-select tracking; a simultaneous end+begin means the next byte has already started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_byte <= 1'b0;
        end else if (byte_begin) begin
            r_in_byte <= 1'b1;
        end else if (byte_end) begin
            r_in_byte <= 1'b0;
        end else begin
            r_in_byte <= r_in_byte;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control decode; a data byte_end beats a coincident timeout.
    always_comb begin
        w_next_state = r_state;
        w_latch_cmd  = 1'b0;
        w_wr_en      = 1'b0;
        w_rd_accept  = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_clear   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (byte_end) begin
                    w_latch_cmd  = 1'b1;
                    w_next_state = ST_WAIT_DATA;
                    if (!rx_data[RW_BIT]) begin
                        w_rd_accept = 1'b1;
                        w_tx_load   = 1'b1;
                    end else begin
                        w_rd_accept = 1'b0;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (byte_end) begin
                    w_next_state = ST_IDLE;
                    if (r_rw) begin
                        w_wr_en = 1'b1;
                    end else begin
                        w_tx_clear = 1'b1;
                    end
                end else if (w_at_limit && !r_in_byte && !byte_begin) begin
                    w_timeout    = 1'b1;
                    w_tx_clear   = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_DATA;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Read-data mux for the addressed register of an incoming read command.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_addr == ADDR_W'(i)) begin
                w_rd_data = w_regs[i];
            end else begin
                w_rd_data = w_rd_data;
            end
        end
    end

    // Command latch, MISO byte, write address and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_tx       <= '0;
            r_wr_addr  <= '0;
            r_wr_pulse <= 1'b0;
            r_rd_pulse <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_latch_cmd) begin
                r_rw   <= rx_data[RW_BIT];
                r_addr <= w_cmd_addr;
            end else begin
                r_rw   <= r_rw;
                r_addr <= r_addr;
            end
            if (w_tx_load) begin
                r_tx <= w_rd_data;
            end else if (w_tx_clear) begin
                r_tx <= '0;
            end else begin
                r_tx <= r_tx;
            end
            if (w_wr_en) begin
                r_wr_addr <= r_addr;
            end else begin
                r_wr_addr <= r_wr_addr;
            end
            r_wr_pulse <= w_wr_en;
            r_rd_pulse <= w_rd_accept;
            r_timeout  <= w_timeout;
            r_busy     <= (w_next_state == ST_WAIT_DATA);
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] r_reg;

        // One bank entry; only a completed write frame to this address updates it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_reg <= '0;
            end else if (w_wr_en && (r_addr == ADDR_W'(gi))) begin
                r_reg <= rx_data;
            end else begin
                r_reg <= r_reg;
            end
        end

        assign w_regs[gi]                        = r_reg;
        assign regs_flat[gi*DATA_W +: DATA_W]    = r_reg;
    end

    assign tx_data     = r_tx;
    assign wr_pulse    = r_wr_pulse;
    assign wr_addr     = r_wr_addr;
    assign rd_pulse    = r_rd_pulse;
    assign timeout_err = r_timeout;
    assign busy        = r_busy;

endmodule
